// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word and RAM handshake encodings, plus the
// memory arbiter's grant states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_IGRANT = 2'd1,
        ARB_DGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating run-length counter; clear takes priority over increment.
module arb_streak_counter #(
    parameter int MAX = 3
) (
    input  logic CLK,
    input  logic nRST,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int W = (MAX < 2) ? 1 : $clog2(MAX + 1);

    logic [W-1:0] count_q, count_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) count_q <= '0;
        else       count_q <= count_d;
    end

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && count_q != W'(MAX))
            count_d = count_q + W'(1);
    end

    assign at_max = (count_q == W'(MAX));

endmodule

// File: rtl/mem_request_arbiter.sv
// Arbitrates the single-ported RAM between fetch and data ports: data first,
// with a bounded data streak so a waiting fetch always gets through.
module mem_request_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_DSTREAK = 3
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      iwait,
    output logic      dwait,
    output word_t     iload,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      err_flag
);

    arb_state_t state_q, state_d;
    logic       err_flag_q, err_flag_d;
    logic       d_req, i_done, d_done, streak_max;

    assign d_req  = dREN | dWEN;
    assign i_done = (state_q == ARB_IGRANT) && iREN  && (ramstate == ACCESS);
    assign d_done = (state_q == ARB_DGRANT) && d_req && (ramstate == ACCESS);

    // Only data completions that made a fetch wait count toward the streak.
    arb_streak_counter #(.MAX(MAX_DSTREAK)) u_streak (
        .CLK    (CLK),
        .nRST   (nRST),
        .inc    (d_done & iREN),
        .clr    (i_done | (d_done & ~iREN)),
        .at_max (streak_max)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= ARB_IDLE;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_flag_q <= err_flag_d;
        end
    end

    // A dropped request (abort) or a completed access both return to IDLE;
    // ERROR keeps the grant so the RAM retries.
    always_comb begin
        state_d    = state_q;
        err_flag_d = err_flag_q | ((state_q != ARB_IDLE) && (ramstate == ERROR));
        case (state_q)
            ARB_IDLE: begin
                if (d_req && (!streak_max || !iREN)) state_d = ARB_DGRANT;
                else if (iREN)                       state_d = ARB_IGRANT;
            end
            ARB_IGRANT: if (!iREN  || ramstate == ACCESS) state_d = ARB_IDLE;
            ARB_DGRANT: if (!d_req || ramstate == ACCESS) state_d = ARB_IDLE;
            default:    state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            ARB_IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = !i_done;
            end
            ARB_DGRANT: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = !d_done;
            end
            default: ;
        endcase
    end

    assign iload    = ramload;
    assign dload    = ramload;
    assign err_flag = err_flag_q;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed scenarios followed by a randomized run scored against a
// transaction-level memory model and fairness/exclusivity rules.
module tb_mem_request_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore;
    logic      iwait, dwait, ramREN, ramWEN, err_flag;
    word_t     iload, dload, ramaddr, ramstore, ramload;
    ramstate_t ramstate;

    mem_request_arbiter #(.MAX_DSTREAK(3)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err_flag(err_flag)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    function automatic word_t seed(input logic [9:0] a);
        return ({22'h0, a} * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // RAM model: latency counted in strobed cycles, optional one-shot ERROR
    // slot, or a per-cycle random status in random mode.
    word_t     mem [0:1023];
    logic      mem_vld [0:1023];
    int        ram_cnt = 0;
    int        ram_lat = 0;
    int        ram_err_at = -1;
    logic      rand_mode = 1'b0;
    ramstate_t rs_rand = BUSY;
    logic      pre_we = 1'b0;
    logic [9:0] pre_addr = '0;
    word_t     pre_data = '0;

    always_comb begin
        if (!(ramREN || ramWEN))    ramstate = FREE;
        else if (rand_mode)         ramstate = rs_rand;
        else if (ram_cnt == ram_err_at) ramstate = ERROR;
        else if (ram_cnt >= ram_lat)    ramstate = ACCESS;
        else                        ramstate = BUSY;
    end

    always_comb begin
        ramload = (mem_vld[ramaddr[9:0]] === 1'b1) ? mem[ramaddr[9:0]] : seed(ramaddr[9:0]);
    end

    always @(posedge CLK) begin
        if (pre_we) begin
            mem[pre_addr]     <= pre_data;
            mem_vld[pre_addr] <= 1'b1;
        end
        if (ramWEN && ramstate == ACCESS) begin
            mem[ramaddr[9:0]]     <= ramstore;
            mem_vld[ramaddr[9:0]] <= 1'b1;
        end
        if ((ramREN || ramWEN) && ramstate != ACCESS) ram_cnt <= ram_cnt + 1;
        else                                          ram_cnt <= 0;
    end

    // Reference memory as seen by the requesters.
    word_t ref_mem [0:1023];
    bit    ref_vld [0:1023];

    function automatic word_t ref_rd(input logic [9:0] a);
        return ref_vld[a] ? ref_mem[a] : seed(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input word_t d);
        pre_addr = a; pre_data = d; pre_we = 1'b1;
        ref_mem[a] = d; ref_vld[a] = 1'b1;
        @(posedge CLK); #1;
        pre_we = 1'b0;
    endtask

    task automatic cyc();
        @(posedge CLK); #1;
    endtask

    int viol = 0;

    // Samples each negedge until the chosen port's wait drops; n = cycles seen.
    task automatic wait_done(input bit is_i, input int maxc, input string tag, output int n);
        n = 0;
        forever begin
            @(negedge CLK);
            n++;
            if ((ramREN && ramWEN) || (!iwait && !dwait)) viol++;
            if ((is_i ? iwait : dwait) == 1'b0) return;
            if (n >= maxc) begin
                total++; bad++;
                $error("FAIL %s timeout: waited=%0d cycles limit=%0d", tag, n, maxc);
                return;
            end
        end
    endtask

    initial begin
        int n;
        logic [7:0] seq;
        int k;
        bit ip, dp, i_fin, d_fin, ref_err;
        int d_since_i, i_age, max_age;

        iREN = 0; dREN = 0; dWEN = 0; iaddr = '0; daddr = '0; dstore = '0;
        nRST = 1'b0;
        for (int a = 0; a < 1024; a++) ref_vld[a] = 1'b0;
        preload(10'h040, 32'h8C010004);
        preload(10'h044, 32'h13572468);

        // reset state
        #2;
        chk("rst_iwait", iwait, 1); chk("rst_dwait", dwait, 1);
        chk("rst_ramREN", ramREN, 0); chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0); chk("rst_ramstore", ramstore, 0);
        chk("rst_err", err_flag, 0);
        cyc(); nRST = 1'b1;

        // lone fetch, two BUSY cycles
        ram_lat = 2;
        cyc(); iREN = 1; iaddr = 32'h40;
        wait_done(1, 20, "lone", n);
        chk("lone_lat", n, 4);
        chk("lone_iload", iload, 32'h8C010004);
        chk("lone_dwait", dwait, 1);
        cyc(); iREN = 0;
        @(negedge CLK);
        chk("lone_iwait_after", iwait, 1); chk("lone_idle_ren", ramREN, 0);

        // collision: data write wins, then fetch
        ram_lat = 1;
        cyc(); iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        wait_done(0, 20, "coll_d", n);
        chk("coll_d_lat", n, 3);
        chk("coll_iwait_hold", iwait, 1);
        chk("coll_ramWEN", ramWEN, 1);
        chk("coll_ramaddr", ramaddr, 32'h100);
        chk("coll_ramstore", ramstore, 32'hDEADBEEF);
        ref_mem[10'h100] = 32'hDEADBEEF; ref_vld[10'h100] = 1'b1;
        cyc(); dWEN = 0;
        wait_done(1, 20, "coll_i", n);
        chk("coll_i_lat", n, 3);
        chk("coll_iload", iload, 32'h13572468);
        cyc(); iREN = 0;

        ram_lat = 0;
        dREN = 1; daddr = 32'h100;
        wait_done(0, 10, "readback", n);
        chk("readback_dload", dload, 32'hDEADBEEF);
        cyc(); dREN = 0;

        // starvation bound: D D D I D D D I
        cyc(); iREN = 1; iaddr = 32'h40; dREN = 1; daddr = 32'h100;
        seq = '0; k = 0;
        for (int c = 0; c < 80 && k < 8; c++) begin
            @(negedge CLK);
            if ((ramREN && ramWEN) || (!iwait && !dwait)) viol++;
            if (!iwait) begin seq[k] = 1'b1; k++; end
            else if (!dwait) begin seq[k] = 1'b0; k++; end
        end
        chk("starve_count", k, 8);
        chk("starve_seq", seq, 8'h88);
        cyc(); iREN = 0; dREN = 0;
        cyc();

        // abort in the second DGRANT cycle
        ram_lat = 3;
        dREN = 1; daddr = 32'h200;
        @(negedge CLK); chk("abort_idle_ren", ramREN, 0);
        @(negedge CLK); chk("abort_grant_ren", ramREN, 1);
        cyc(); dREN = 0;
        @(negedge CLK);
        chk("abort_ren_drop", ramREN, 0); chk("abort_no_pulse", dwait, 1);
        cyc(); dREN = 1; ram_lat = 0;
        @(negedge CLK); chk("abort_then_idle", ramREN, 0);
        @(negedge CLK);
        chk("abort_retry_dwait", dwait, 0); chk("abort_retry_dload", dload, seed(10'h200));
        cyc(); dREN = 0;

        // ERROR then ACCESS during a fetch
        ram_lat = 1; ram_err_at = 0;
        chk("err_clear", err_flag, 0);
        cyc(); iREN = 1; iaddr = 32'h44;
        @(negedge CLK);
        @(negedge CLK);
        chk("err_iwait_hold", iwait, 1); chk("err_ren_hold", ramREN, 1);
        @(negedge CLK);
        chk("err_flag_set", err_flag, 1);
        chk("err_complete", iwait, 0); chk("err_iload", iload, 32'h13572468);
        cyc(); iREN = 0; ram_err_at = -1;
        @(negedge CLK); chk("err_iwait_after", iwait, 1);
        cyc(); cyc();
        chk("err_sticky", err_flag, 1);

        // reset in the middle of a write grant
        ram_lat = 5;
        cyc(); dWEN = 1; daddr = 32'h300; dstore = 32'hCAFEF00D;
        @(negedge CLK);
        @(negedge CLK); chk("rmid_wen_before", ramWEN, 1);
        #2 nRST = 1'b0;
        #1;
        chk("rmid_wen", ramWEN, 0); chk("rmid_iwait", iwait, 1);
        chk("rmid_dwait", dwait, 1); chk("rmid_err", err_flag, 0);
        chk("rmid_addr", ramaddr, 0);
        dWEN = 0;
        @(posedge CLK); #1 nRST = 1'b1;
        @(negedge CLK);
        chk("rmid_post_wen", ramWEN, 0); chk("rmid_post_ren", ramREN, 0);
        cyc(); ram_lat = 0; dREN = 1; daddr = 32'h300;
        wait_done(0, 10, "rmid_read", n);
        chk("rmid_no_write", dload, seed(10'h300));
        cyc(); dREN = 0;
        chk("directed_excl", viol, 0);

        // randomized traffic against the reference model
        rand_mode = 1'b1;
        ip = 0; dp = 0; i_fin = 0; d_fin = 0; ref_err = 0;
        d_since_i = 0; i_age = 0; max_age = 0;
        for (int c = 0; c < 3000; c++) begin
            int r;
            @(posedge CLK); #1;
            if (i_fin) begin ip = 0; iREN = 0; end
            if (d_fin) begin dp = 0; dREN = 0; dWEN = 0; end
            if (ip && $urandom_range(0, 39) == 0) begin ip = 0; iREN = 0; end
            if (dp && $urandom_range(0, 29) == 0) begin dp = 0; dREN = 0; dWEN = 0; end
            if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1; iREN = 1; iaddr = 32'($urandom_range(0, 1023));
                d_since_i = 0; i_age = 0;
            end
            if (!dp && $urandom_range(0, 1) == 0) begin
                dp = 1; daddr = 32'($urandom_range(0, 1023)); dstore = $urandom;
                if ($urandom_range(0, 1) == 0) begin dREN = 1; dWEN = 0; end
                else begin dREN = 0; dWEN = 1; end
            end
            r = $urandom_range(0, 19);
            rs_rand = (r == 0) ? ERROR : (r < 9) ? ACCESS : BUSY;
            @(negedge CLK);
            i_fin = !iwait; d_fin = !dwait;
            chk("r_excl", {(ramREN && ramWEN), (!iwait && !dwait)}, 2'b00);
            chk("r_err", err_flag, ref_err);
            if (ramstate == ERROR) ref_err = 1;
            if (ramWEN) begin
                chk("r_wr_addr", ramaddr, daddr); chk("r_wr_data", ramstore, dstore);
            end
            if (i_fin) begin
                chk("r_i_req", {ip, ramstate}, {1'b1, ACCESS});
                chk("r_iload", iload, ref_rd(iaddr[9:0]));
                d_since_i = 0;
            end
            if (d_fin) begin
                chk("r_d_req", {dp, ramstate}, {1'b1, ACCESS});
                if (dREN) chk("r_dload", dload, ref_rd(daddr[9:0]));
                else begin ref_mem[daddr[9:0]] = dstore; ref_vld[daddr[9:0]] = 1'b1; end
                if (ip) begin
                    d_since_i++;
                    chk("r_starve", d_since_i <= 3, 1);
                end
            end
            if (ip && !i_fin) begin
                i_age++;
                if (i_age > max_age) max_age = i_age;
            end
        end
        chk("r_progress", max_age < 300, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
